// File: rtl/face_pos_stabilizer_pkg.sv
// Shared widths, the no-eye code and the per-slot record for face_pos_stabilizer.
package face_pos_stabilizer_pkg;
   localparam int COORD_W   = 7;
   localparam int NUM_FACES = 2;
   localparam int MISS_W    = 4;
   localparam logic [2*COORD_W-1:0] NO_EYE = '0;

   typedef logic [COORD_W-1:0] coord_t;

   typedef struct packed {
      coord_t x;
      coord_t y;
      coord_t e1r;
      coord_t e1c;
      coord_t e2r;
      coord_t e2c;
   } face_t;
endpackage

// File: rtl/face_pos_stabilizer_slot_track.sv
// One face slot: candidate buffer, miss/hold counters and the smoothing datapath.
// FACE_SMOOTH_EN selects IIR smoothing with jump snap and eye hold; otherwise values pass through.
module face_slot_track
   import face_pos_stabilizer_pkg::*;
#(
   parameter int SHIFT       = 2,
   parameter int JUMP_TH     = 12,
   parameter int HOLD_FRAMES = 4
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  commit,
   input  logic  det_we,
   input  face_t det,
   output logic  active,
   output face_t cur
);
`ifdef FACE_SMOOTH_EN
   localparam bit SMOOTH_EN = 1'b1;
`else
   localparam bit SMOOTH_EN = 1'b0;
`endif
   localparam logic [MISS_W-1:0] HM  = MISS_W'(HOLD_FRAMES);
   localparam logic signed [7:0] JTH = 8'(JUMP_TH);

   typedef struct packed {
      coord_t            r;
      coord_t            c;
      logic [MISS_W-1:0] m;
   } eye_t;

   face_t             cand;
   face_t             nxt;
   eye_t              e1_nx, e2_nx;
   logic              seen, e1_none, e2_none;
   logic [MISS_W-1:0] miss, e1_miss, e2_miss;

   function automatic coord_t smooth(coord_t c, coord_t n);
      logic signed [7:0] d, step;
      logic signed [8:0] sum;
      d = $signed({1'b0, n}) - $signed({1'b0, c});
      if (d > JTH || d < -JTH) return n;
      step = d >>> SHIFT;
      if (d != 8'sd0 && step == 8'sd0) step = d[7] ? -8'sd1 : 8'sd1;
      sum = $signed({2'b00, c}) + $signed({step[7], step});
      if (sum < 9'sd0) return '0;
      if (sum > 9'sd127) return 7'd127;
      return sum[6:0];
   endfunction

   // A missing eye keeps its last value until the miss counter expires;
   // an eye returning after expiry is loaded directly rather than ramped from zero.
   function automatic eye_t eye_step(eye_t e, coord_t nr, coord_t nc);
      eye_t o;
      o = e;
      if ({nr, nc} == NO_EYE) begin
         if (e.m >= HM - 1'b1) o = '{r: '0, c: '0, m: HM};
         else                  o.m = e.m + 1'b1;
      end else if (e.m == HM) begin
         o = '{r: nr, c: nc, m: '0};
      end else begin
         o = '{r: smooth(e.r, nr), c: smooth(e.c, nc), m: '0};
      end
      return o;
   endfunction

   assign e1_none = ({cand.e1r, cand.e1c} == NO_EYE);
   assign e2_none = ({cand.e2r, cand.e2c} == NO_EYE);

   always_comb begin
      nxt   = cand;
      e1_nx = '{r: cand.e1r, c: cand.e1c, m: (e1_none ? HM : '0)};
      e2_nx = '{r: cand.e2r, c: cand.e2c, m: (e2_none ? HM : '0)};
      if (SMOOTH_EN) begin
         nxt.x   = smooth(cur.x, cand.x);
         nxt.y   = smooth(cur.y, cand.y);
         e1_nx   = eye_step('{r: cur.e1r, c: cur.e1c, m: e1_miss}, cand.e1r, cand.e1c);
         e2_nx   = eye_step('{r: cur.e2r, c: cur.e2c, m: e2_miss}, cand.e2r, cand.e2c);
         nxt.e1r = e1_nx.r;
         nxt.e1c = e1_nx.c;
         nxt.e2r = e2_nx.r;
         nxt.e2c = e2_nx.c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cand    <= '0;
         seen    <= 1'b0;
         miss    <= HM;
         e1_miss <= HM;
         e2_miss <= HM;
         active  <= 1'b0;
         cur     <= '0;
      end else if (commit) begin
         // a strobe landing on the commit cycle seeds the next frame
         cand <= det_we ? det : '0;
         seen <= det_we;
         if (seen) begin
            miss   <= '0;
            active <= 1'b1;
            if (active) begin
               cur     <= nxt;
               e1_miss <= e1_nx.m;
               e2_miss <= e2_nx.m;
            end else begin
               cur     <= cand;
               e1_miss <= e1_none ? HM : '0;
               e2_miss <= e2_none ? HM : '0;
            end
         end else if (miss >= HM - 1'b1) begin
            miss    <= HM;
            active  <= 1'b0;
            cur     <= '0;
            e1_miss <= HM;
            e2_miss <= HM;
         end else begin
            miss <= miss + 1'b1;
         end
      end else if (det_we) begin
         cand <= det;
         seen <= 1'b1;
      end
   end
endmodule

// File: rtl/face_pos_stabilizer.sv
// Frame-synchronous face/eye position stabilizer feeding the filter overlay.
// Optional smoothing is enabled by defining FACE_SMOOTH_EN.
module face_pos_stabilizer
   import face_pos_stabilizer_pkg::*;
#(
   parameter int SHIFT       = 2,
   parameter int JUMP_TH     = 12,
   parameter int HOLD_FRAMES = 4
) (
   input  logic       iCLK,
   input  logic       iRST_N,
   input  logic       iVS,
   input  logic [1:0] iSTYLE,
   input  logic       iDET_VALID,
   input  logic       iDET_ID,
   input  logic [6:0] iDET_X,
   input  logic [6:0] iDET_Y,
   input  logic [6:0] iDET_E1R,
   input  logic [6:0] iDET_E1C,
   input  logic [6:0] iDET_E2R,
   input  logic [6:0] iDET_E2C,
   output logic [1:0] oNUM,
   output logic [1:0] oSTYLE,
   output logic [6:0] oPOS_X1,
   output logic [6:0] oPOS_Y1,
   output logic [6:0] oPOS_X2,
   output logic [6:0] oPOS_Y2,
   output logic [6:0] oEYEROW11,
   output logic [6:0] oEYECOL11,
   output logic [6:0] oEYEROW12,
   output logic [6:0] oEYECOL12,
   output logic [6:0] oEYEROW21,
   output logic [6:0] oEYECOL21,
   output logic [6:0] oEYEROW22,
   output logic [6:0] oEYECOL22,
   output logic       oCOMMIT
);
   logic  vs_p0, vs_p1, commit;
   logic  act0, act1;
   face_t det, s0, s1, f1, f2;

   assign commit = vs_p0 & ~vs_p1;
   assign det    = '{x: iDET_X, y: iDET_Y, e1r: iDET_E1R, e1c: iDET_E1C,
                     e2r: iDET_E2R, e2c: iDET_E2C};

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         vs_p0   <= 1'b0;
         vs_p1   <= 1'b0;
         oCOMMIT <= 1'b0;
         oSTYLE  <= '0;
      end else begin
         vs_p0   <= iVS;
         vs_p1   <= vs_p0;
         oCOMMIT <= commit;
         if (commit) oSTYLE <= iSTYLE;
      end
   end

   face_slot_track #(.SHIFT(SHIFT), .JUMP_TH(JUMP_TH), .HOLD_FRAMES(HOLD_FRAMES)) u_slot0 (
      .clk(iCLK), .rst_n(iRST_N), .commit(commit),
      .det_we(iDET_VALID & ~iDET_ID), .det(det), .active(act0), .cur(s0)
   );

   face_slot_track #(.SHIFT(SHIFT), .JUMP_TH(JUMP_TH), .HOLD_FRAMES(HOLD_FRAMES)) u_slot1 (
      .clk(iCLK), .rst_n(iRST_N), .commit(commit),
      .det_we(iDET_VALID & iDET_ID), .det(det), .active(act1), .cur(s1)
   );

   // a lone slot 1 is packed into the first output set
   always_comb begin
      f1 = '0;
      f2 = '0;
      if (act0) begin
         f1 = s0;
         if (act1) f2 = s1;
      end else if (act1) begin
         f1 = s1;
      end
   end

   assign oNUM      = {1'b0, act0} + {1'b0, act1};
   assign oPOS_X1   = f1.x;
   assign oPOS_Y1   = f1.y;
   assign oPOS_X2   = f2.x;
   assign oPOS_Y2   = f2.y;
   assign oEYEROW11 = f1.e1r;
   assign oEYECOL11 = f1.e1c;
   assign oEYEROW12 = f1.e2r;
   assign oEYECOL12 = f1.e2c;
   assign oEYEROW21 = f2.e1r;
   assign oEYECOL21 = f2.e1c;
   assign oEYEROW22 = f2.e2r;
   assign oEYECOL22 = f2.e2c;
endmodule

// File: tb/tb_face_pos_stabilizer.sv
// Directed table-driven bench for face_pos_stabilizer (expectations follow FACE_SMOOTH_EN).
`ifdef FACE_SMOOTH_EN
`define SM(a, b) (a)
`else
`define SM(a, b) (b)
`endif
module tb_face_pos_stabilizer;
   logic       iCLK = 1'b0, iRST_N = 1'b0, iVS = 1'b0, iDET_VALID = 1'b0, iDET_ID = 1'b0;
   logic [1:0] iSTYLE = 2'd0;
   logic [6:0] iDET_X = '0, iDET_Y = '0, iDET_E1R = '0, iDET_E1C = '0, iDET_E2R = '0, iDET_E2C = '0;
   logic [1:0] oNUM, oSTYLE;
   logic [6:0] oPOS_X1, oPOS_Y1, oPOS_X2, oPOS_Y2;
   logic [6:0] oEYEROW11, oEYECOL11, oEYEROW12, oEYECOL12;
   logic [6:0] oEYEROW21, oEYECOL21, oEYEROW22, oEYECOL22;
   logic       oCOMMIT;

   face_pos_stabilizer #(.SHIFT(2), .JUMP_TH(12), .HOLD_FRAMES(4)) dut (
      .iCLK(iCLK), .iRST_N(iRST_N), .iVS(iVS), .iSTYLE(iSTYLE),
      .iDET_VALID(iDET_VALID), .iDET_ID(iDET_ID), .iDET_X(iDET_X), .iDET_Y(iDET_Y),
      .iDET_E1R(iDET_E1R), .iDET_E1C(iDET_E1C), .iDET_E2R(iDET_E2R), .iDET_E2C(iDET_E2C),
      .oNUM(oNUM), .oSTYLE(oSTYLE),
      .oPOS_X1(oPOS_X1), .oPOS_Y1(oPOS_Y1), .oPOS_X2(oPOS_X2), .oPOS_Y2(oPOS_Y2),
      .oEYEROW11(oEYEROW11), .oEYECOL11(oEYECOL11), .oEYEROW12(oEYEROW12), .oEYECOL12(oEYECOL12),
      .oEYEROW21(oEYEROW21), .oEYECOL21(oEYECOL21), .oEYEROW22(oEYEROW22), .oEYECOL22(oEYECOL22),
      .oCOMMIT(oCOMMIT)
   );

   always #5 iCLK = ~iCLK;

   typedef struct packed {
      logic       id;
      logic [6:0] x, y, er, ec;
   } det_t;

   typedef struct packed {
      logic [1:0]     nd;
      det_t [2:0]     d;
      logic [1:0]     num;
      logic [6:0]     x1, y1, x2, y2, er, ec;
   } vec_t;

   vec_t tv[11];
   int   errors = 0;
   int   checks = 0;

   function automatic det_t D(logic id, int x, int y, int er, int ec);
      return '{id: id, x: 7'(x), y: 7'(y), er: 7'(er), ec: 7'(ec)};
   endfunction

   function automatic vec_t V(int nd, det_t d0, det_t d1, int num,
                              int x1, int y1, int x2, int y2, int er, int ec);
      vec_t v;
      v.nd = 2'(nd);
      v.d[0] = d0; v.d[1] = d1; v.d[2] = '0;
      v.num = 2'(num);
      v.x1 = 7'(x1); v.y1 = 7'(y1); v.x2 = 7'(x2); v.y2 = 7'(y2);
      v.er = 7'(er); v.ec = 7'(ec);
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic put(input det_t d);
      iDET_VALID = 1'b1; iDET_ID = d.id;
      iDET_X = d.x; iDET_Y = d.y; iDET_E1R = d.er; iDET_E1C = d.ec;
      iDET_E2R = '0; iDET_E2C = '0;
   endtask

   task automatic strobe(input det_t d);
      @(negedge iCLK); put(d);
      @(negedge iCLK); iDET_VALID = 1'b0;
   endtask

   // raise iVS; optionally present a strobe in the commit cycle itself
   task automatic commit_frame(input logic cv, input det_t cd, input int hold);
      int pulses;
      @(negedge iCLK); iVS = 1'b1;
      @(negedge iCLK);
      chk("commit_early", oCOMMIT, 0);
      if (cv) put(cd);
      @(negedge iCLK);
      iDET_VALID = 1'b0;
      chk("commit_pulse", oCOMMIT, 1);
      pulses = int'(oCOMMIT);
      repeat (hold) begin
         @(negedge iCLK);
         if (oCOMMIT) pulses++;
      end
      chk("commit_once", pulses, 1);
      iVS = 1'b0;
      repeat (3) @(negedge iCLK);
   endtask

   task automatic chk_out(input string tag, input vec_t v);
      chk({tag, "_num"}, oNUM, v.num);
      chk({tag, "_x1"}, oPOS_X1, v.x1);
      chk({tag, "_y1"}, oPOS_Y1, v.y1);
      chk({tag, "_x2"}, oPOS_X2, v.x2);
      chk({tag, "_y2"}, oPOS_Y2, v.y2);
      chk({tag, "_er11"}, oEYEROW11, v.er);
      chk({tag, "_ec11"}, oEYECOL11, v.ec);
   endtask

   initial begin
      det_t z;
      z = '0;
      tv[0]  = V(1, D(0, 40, 30, 10, 12), z, 1, 40, 30, 0, 0, 10, 12);
      tv[1]  = V(1, D(0, 48, 30, 0, 0), z, 1, `SM(42, 48), 30, 0, 0, `SM(10, 0), `SM(12, 0));
      tv[2]  = V(1, D(0, 60, 30, 0, 0), z, 1, 60, 30, 0, 0, `SM(10, 0), `SM(12, 0));
      tv[3]  = V(1, D(0, 60, 26, 11, 12), z, 1, 60, `SM(29, 26), 0, 0, 11, 12);
      tv[4]  = V(0, z, z, 1, 60, `SM(29, 26), 0, 0, 11, 12);
      tv[5]  = V(0, z, z, 1, 60, `SM(29, 26), 0, 0, 11, 12);
      tv[6]  = V(0, z, z, 1, 60, `SM(29, 26), 0, 0, 11, 12);
      tv[7]  = V(0, z, z, 0, 0, 0, 0, 0, 0, 0);
      tv[8]  = V(1, D(1, 20, 20, 0, 0), z, 1, 20, 20, 0, 0, 0, 0);
      tv[9]  = V(2, D(0, 40, 30, 0, 0), D(1, 22, 20, 0, 0), 2, 40, 30, `SM(21, 22), 20, 0, 0);
      tv[10] = V(2, D(0, 100, 100, 5, 5), D(0, 40, 31, 0, 0), 2, 40, 31, `SM(21, 22), 20, 0, 0);

      repeat (3) @(negedge iCLK);
      chk("rst_num", oNUM, 0);
      chk("rst_x1", oPOS_X1, 0);
      chk("rst_commit", oCOMMIT, 0);
      chk("rst_style", oSTYLE, 0);
      iRST_N = 1'b1;
      iSTYLE = 2'd2;
      repeat (2) @(negedge iCLK);

      for (int i = 0; i < 11; i++) begin
         for (int j = 0; j < int'(tv[i].nd); j++) strobe(tv[i].d[j]);
         commit_frame(1'b0, z, 2);
         chk_out($sformatf("frame%0d", i), tv[i]);
      end

      chk("style_latched", oSTYLE, 2);
      iSTYLE = 2'd1;
      repeat (5) @(negedge iCLK);
      chk("style_hold", oSTYLE, 2);
      commit_frame(1'b0, z, 2);
      chk("style_update", oSTYLE, 1);

      // reset in mid-frame discards the captured detection
      strobe(D(0, 30, 30, 0, 0));
      @(negedge iCLK); iRST_N = 1'b0;
      @(negedge iCLK);
      chk("midrst_num", oNUM, 0);
      chk("midrst_x2", oPOS_X2, 0);
      iRST_N = 1'b1;
      commit_frame(1'b0, z, 2);
      chk("after_rst_num", oNUM, 0);
      chk("after_rst_x1", oPOS_X1, 0);

      // strobe in the commit cycle lands in the following frame; long iVS
      commit_frame(1'b1, D(0, 70, 70, 0, 0), 20);
      chk("coinc_num", oNUM, 0);
      chk("coinc_x1", oPOS_X1, 0);
      commit_frame(1'b0, z, 2);
      chk("next_num", oNUM, 1);
      chk("next_x1", oPOS_X1, 70);
      chk("next_y1", oPOS_Y1, 70);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
